// File: rtl/pwm_pkg.sv
// Shared register map, mode bit positions and resolution helper for the PWM peripheral.
package pwm_pkg;

    localparam logic [6:0] ADDR_OUT_EN_LO = 7'h00;
    localparam logic [6:0] ADDR_OUT_EN_HI = 7'h01;
    localparam logic [6:0] ADDR_PWM_EN_LO = 7'h02;
    localparam logic [6:0] ADDR_PWM_EN_HI = 7'h03;
    localparam logic [6:0] ADDR_PRESC     = 7'h04;
    localparam logic [6:0] ADDR_MODE      = 7'h05;
    localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;

    localparam int MODE_CENTRE = 0;
    localparam int MODE_INVERT = 1;
    localparam int MODE_FORCE  = 2;

    function automatic int pwm_maxv(input int res);
        return (1 << res) - 1;
    endfunction

endpackage

// File: rtl/pwm_multi_peripheral_timebase.sv
// Shared PWM timebase: prescaler, edge/centre up-down counter and period-boundary detection.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int RES     = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] presc,
    input  logic               presc_restart,
    input  logic               centre_req,
    output logic [RES-1:0]     cnt,
    output logic               tick,
    output logic               boundary
);

    localparam logic [RES-1:0] MAXV = RES'(pwm_maxv(RES));
    localparam logic [RES-1:0] ONE  = RES'(1);

    logic [PRESC_W-1:0] pcnt;
    logic               dir_up;
    logic               centre_active;

    assign tick = (pcnt == presc);

    // A period ends on the tick that brings the counter back to zero.
    always_comb begin
        boundary = 1'b0;
        if (tick) begin
            if (centre_active) boundary = !dir_up && (cnt == ONE);
            else               boundary = (cnt == MAXV);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt          <= '0;
            cnt           <= '0;
            dir_up        <= 1'b1;
            centre_active <= 1'b0;
        end else begin
            if (presc_restart || tick) pcnt <= '0;
            else                       pcnt <= pcnt + 1'b1;

            if (tick) begin
                if (boundary) begin
                    cnt           <= '0;
                    dir_up        <= 1'b1;
                    centre_active <= centre_req;
                end else if (!centre_active) begin
                    cnt <= cnt + 1'b1;
                end else if (dir_up) begin
                    if (cnt == MAXV) begin
                        dir_up <= 1'b0;
                        cnt    <= MAXV - 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_multi_peripheral.sv
// Multi-channel PWM peripheral: register file, double-buffered duties and per-channel compare.
module pwm_multi_peripheral
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int RES     = 8,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [6:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [6:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam logic [RES-1:0] MAXV = RES'(pwm_maxv(RES));

    logic               wr_en_p0;
    logic [6:0]         wr_addr_p0;
    logic [7:0]         wr_data_p0;
    logic [NUM_CH-1:0]  out_en, pwm_en;
    logic [15:0]        out_en_w, pwm_en_w, out_en_nxt, pwm_en_nxt;
    logic [PRESC_W-1:0] presc;
    logic               mode_centre, mode_invert;
    logic               presc_restart, force_load;
    logic [RES-1:0]     duty_shadow [NUM_CH];
    logic [RES-1:0]     duty_active [NUM_CH];
    logic [NUM_CH-1:0]  duty_wr, pwm_nxt;
    logic [RES-1:0]     cnt;
    logic               tick, boundary;

    // Write stage p0: the strobe is registered once before it reaches the register file.
    always_ff @(posedge clk) begin
        if (rst) wr_en_p0 <= 1'b0;
        else     wr_en_p0 <= wr_en;
        wr_addr_p0 <= wr_addr;
        wr_data_p0 <= wr_data;
    end

    assign out_en_w      = 16'(out_en);
    assign pwm_en_w      = 16'(pwm_en);
    assign presc_restart = wr_en_p0 && (wr_addr_p0 == ADDR_PRESC);
    assign force_load    = wr_en_p0 && (wr_addr_p0 == ADDR_MODE) && wr_data_p0[MODE_FORCE];

    always_comb begin
        out_en_nxt = out_en_w;
        pwm_en_nxt = pwm_en_w;
        if (wr_en_p0) begin
            if (wr_addr_p0 == ADDR_OUT_EN_LO) out_en_nxt[7:0]  = wr_data_p0;
            if (wr_addr_p0 == ADDR_OUT_EN_HI) out_en_nxt[15:8] = wr_data_p0;
            if (wr_addr_p0 == ADDR_PWM_EN_LO) pwm_en_nxt[7:0]  = wr_data_p0;
            if (wr_addr_p0 == ADDR_PWM_EN_HI) pwm_en_nxt[15:8] = wr_data_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_en       <= '0;
            pwm_en       <= '0;
            presc        <= '0;
            mode_centre  <= 1'b0;
            mode_invert  <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= '0;
        end else begin
            out_en <= out_en_nxt[NUM_CH-1:0];
            pwm_en <= pwm_en_nxt[NUM_CH-1:0];
            if (presc_restart) presc <= wr_data_p0[PRESC_W-1:0];
            if (wr_en_p0 && (wr_addr_p0 == ADDR_MODE)) begin
                mode_centre <= wr_data_p0[MODE_CENTRE];
                mode_invert <= wr_data_p0[MODE_INVERT];
            end
            period_start <= tick && boundary;
            pwm_out      <= pwm_nxt;
        end
    end

    // Shadow written by the bus; active copied only at a boundary or on force_load,
    // so a write landing on the boundary edge is seen one period later.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rst) begin
                duty_shadow[ch] <= '0;
                duty_active[ch] <= '0;
            end else begin
                if (duty_wr[ch]) duty_shadow[ch] <= wr_data_p0[RES-1:0];
                if (boundary || force_load) duty_active[ch] <= duty_shadow[ch];
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic raw;
        assign duty_wr[ch] = wr_en_p0 && (wr_addr_p0 == ADDR_DUTY_BASE + 7'(ch));
        assign raw         = (duty_active[ch] == MAXV) || (cnt < duty_active[ch]);
        assign pwm_nxt[ch] = out_en[ch] && (!pwm_en[ch] || (raw ^ mode_invert));
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_OUT_EN_LO: rd_data = out_en_w[7:0];
            ADDR_OUT_EN_HI: rd_data = out_en_w[15:8];
            ADDR_PWM_EN_LO: rd_data = pwm_en_w[7:0];
            ADDR_PWM_EN_HI: rd_data = pwm_en_w[15:8];
            ADDR_PRESC:     rd_data = 8'(presc);
            ADDR_MODE:      rd_data = {6'b0, mode_invert, mode_centre};
            default: begin
                if ((rd_addr[6:4] == ADDR_DUTY_BASE[6:4]) && ({1'b0, rd_addr[3:0]} < 5'(NUM_CH)))
                    rd_data = 8'(duty_shadow[rd_addr[3:0]]);
            end
        endcase
    end

    pwm_timebase #(
        .RES     (RES),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk           (clk),
        .rst           (rst),
        .presc         (presc),
        .presc_restart (presc_restart),
        .centre_req    (mode_centre),
        .cnt           (cnt),
        .tick          (tick),
        .boundary      (boundary)
    );

endmodule

// File: tb/tb_pwm_multi_peripheral.sv
// Directed bench for pwm_multi_peripheral (NUM_CH=16, RES=8) with hand-computed expectations.
module tb_pwm_multi_peripheral;

    localparam int NUM_CH  = 16;
    localparam int RES     = 8;
    localparam int PRESC_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [6:0]        wr_addr;
    logic [7:0]        wr_data;
    logic [6:0]        rd_addr;
    logic [7:0]        rd_data;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pwm_multi_peripheral #(
        .NUM_CH  (NUM_CH),
        .RES     (RES),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Register write; returns once the new value is visible in the register file.
    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_check(input string tag, input logic [6:0] a, input int exp);
        rd_addr = a;
        #1;
        check(tag, int'(rd_data), exp);
    endtask

    task automatic wait_ps(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (period_start) found = 1'b1;
        end
        if (!found) check({tag, "_timeout"}, 0, 1);
    endtask

    // Counts pwm_out[0] high samples over n clocks, optionally issuing one write
    // at sample wr_at, optionally stopping at the next period_start.
    task automatic run(input int n, input int wr_at, input logic [6:0] a, input logic [7:0] d,
                       input bit stop, output int hi, output int len);
        hi  = 0;
        len = n;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            hi += int'(pwm_out[0]);
            if (i == wr_at) begin
                wr_en = 1'b1; wr_addr = a; wr_data = d;
            end else begin
                wr_en = 1'b0;
            end
            if (stop && period_start) begin
                len = i;
                break;
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        int hi, len;
        bit ps_seen;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_period_start", int'(period_start), 0);
        rd_check("rst_out_en", 7'h00, 0);
        rd_check("rst_presc", 7'h04, 0);
        rd_check("rst_duty0", 7'h10, 0);
        rst = 1'b0;

        // Basic 50% duty on channel 0
        wr(7'h00, 8'h01);
        wr(7'h02, 8'h01);
        wr(7'h10, 8'h80);
        wr(7'h06, 8'hAA);
        rd_check("rd_duty0", 7'h10, 128);
        rd_check("rd_out_en", 7'h00, 1);
        rd_check("rd_pwm_en", 7'h02, 1);
        rd_check("rd_unmapped", 7'h06, 0);
        wait_ps("first_ps");
        run(3000, -1, 7'h0, 8'h0, 1'b1, hi, len);
        check("edge_period", len, 256);
        run(256, -1, 7'h0, 8'h0, 1'b0, hi, len);
        check("duty80_high", hi, 128);

        // Duty and enable extremes
        wr(7'h10, 8'h00);
        wait_ps("d00");
        run(256, -1, 7'h0, 8'h0, 1'b0, hi, len);
        check("duty00_high", hi, 0);
        wr(7'h02, 8'h00);
        repeat (2) @(negedge clk);
        run(256, -1, 7'h0, 8'h0, 1'b0, hi, len);
        check("pwm_en0_static", hi, 256);
        wr(7'h02, 8'h01);
        wr(7'h10, 8'hFF);
        wait_ps("dff");
        run(256, -1, 7'h0, 8'h0, 1'b0, hi, len);
        check("dutyFF_high", hi, 256);
        wr(7'h00, 8'h00);
        repeat (2) @(negedge clk);
        run(256, -1, 7'h0, 8'h0, 1'b0, hi, len);
        check("out_en0_low", hi, 0);
        wr(7'h00, 8'h01);

        // Double buffering: mid-period write, then a write landing on the boundary edge
        wr(7'h10, 8'h80);
        wait_ps("dbuf");
        run(256, 100, 7'h10, 8'h40, 1'b0, hi, len);
        check("dbuf_cur_period", hi, 128);
        run(256, -1, 7'h0, 8'h0, 1'b0, hi, len);
        check("dbuf_next_period", hi, 64);
        run(256, 254, 7'h10, 8'h20, 1'b0, hi, len);
        check("bnd_wr_cur", hi, 64);
        run(256, -1, 7'h0, 8'h0, 1'b0, hi, len);
        check("bnd_wr_deferred", hi, 64);
        run(256, -1, 7'h0, 8'h0, 1'b0, hi, len);
        check("bnd_wr_applied", hi, 32);

        // Prescaler 3: four clocks per count
        wr(7'h04, 8'h03);
        wr(7'h10, 8'h10);
        rd_check("rd_presc", 7'h04, 3);
        wait_ps("presc_a");
        wait_ps("presc_b");
        run(3000, -1, 7'h0, 8'h0, 1'b1, hi, len);
        check("presc3_period", len, 1024);
        run(1024, -1, 7'h0, 8'h0, 1'b0, hi, len);
        check("presc3_high", hi, 64);
        run(3000, 1, 7'h04, 8'h03, 1'b1, hi, len);
        check("presc_restart_period", len, 1027);

        // Centre-aligned mode
        wr(7'h04, 8'h00);
        wr(7'h10, 8'h40);
        wr(7'h05, 8'h01);
        wait_ps("centre");
        run(3000, -1, 7'h0, 8'h0, 1'b1, hi, len);
        check("centre_period", len, 510);
        check("centre_high_at_zero", int'(pwm_out[0]), 1);
        run(510, -1, 7'h0, 8'h0, 1'b0, hi, len);
        check("centre_high", hi, 127);
        wr(7'h05, 8'h03);
        @(negedge clk);
        run(510, -1, 7'h0, 8'h0, 1'b0, hi, len);
        check("centre_inv_high", hi, 383);
        rd_check("rd_mode", 7'h05, 3);

        // force_load in edge mode
        wr(7'h05, 8'h00);
        wr(7'h10, 8'h00);
        wait_ps("edge_back_a");
        wait_ps("edge_back_b");
        wr(7'h10, 8'hFF);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 7'h05; wr_data = 8'h04;
        ps_seen = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            wr_en = 1'b0;
            ps_seen |= period_start;
            if (k == 2) check("force_not_yet", int'(pwm_out[0]), 0);
            if (k == 3) check("force_visible", int'(pwm_out[0]), 1);
        end
        check("force_no_ps", int'(ps_seen), 0);
        rd_check("rd_mode_force_clr", 7'h05, 0);

        // Reset mid-period
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pwm_out", int'(pwm_out), 0);
        check("midrst_period_start", int'(period_start), 0);
        rd_check("midrst_out_en", 7'h00, 0);
        rd_check("midrst_duty0", 7'h10, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
